// File: rtl/gshare_bp_pkg.sv
// Shared types and helpers for the gshare branch predictor: counter encodings,
// controller states and the 2-bit saturating counter update.
package gshare_pkg;

  localparam logic [1:0] SNT = 2'b00;
  localparam logic [1:0] WNT = 2'b01;
  localparam logic [1:0] WT  = 2'b10;
  localparam logic [1:0] ST  = 2'b11;

  typedef enum logic {StInit, StRun} state_e;

  function automatic logic [1:0] sat_update(input logic [1:0] cnt, input logic taken);
    if (taken) begin
      return (cnt == ST) ? ST : cnt + 2'd1;
    end
    return (cnt == SNT) ? SNT : cnt - 2'd1;
  endfunction

endpackage

// File: rtl/gshare_bp_if.sv
// Predict/update/statistics bundle between fetch, execute and the gshare predictor.
interface gshare_bp_if #(
  parameter int unsigned ADDR_W = 11,
  parameter int unsigned GHR_W  = 8,
  parameter int unsigned CNT_W  = 16
);
  logic              ready;
  logic              pred_valid;
  logic [ADDR_W-1:0] pred_addr;
  logic              pred_rsp_valid;
  logic              pred_taken;
  logic [GHR_W-1:0]  pred_ghr;
  logic              upd_valid;
  logic [ADDR_W-1:0] upd_addr;
  logic [GHR_W-1:0]  upd_ghr;
  logic              upd_taken;
  logic              upd_mispredict;
  logic [CNT_W-1:0]  stat_updates;
  logic [CNT_W-1:0]  stat_mispreds;

  modport master (
    input  ready, pred_rsp_valid, pred_taken, pred_ghr, stat_updates, stat_mispreds,
    output pred_valid, pred_addr, upd_valid, upd_addr, upd_ghr, upd_taken, upd_mispredict
  );

  modport slave (
    output ready, pred_rsp_valid, pred_taken, pred_ghr, stat_updates, stat_mispreds,
    input  pred_valid, pred_addr, upd_valid, upd_addr, upd_ghr, upd_taken, upd_mispredict
  );
endinterface

// File: rtl/gshare_bp_pht.sv
// Pattern history table: 2**IDX_W two-bit counters, one predict read port and one
// write port that either stores WNT (init sweep) or saturates the addressed counter.
module gshare_pht
  import gshare_pkg::*;
#(
  parameter int unsigned IDX_W = 10
) (
  input  logic             clk,
  input  logic [IDX_W-1:0] rd_idx,
  output logic [1:0]       rd_cnt,
  input  logic             wr_en,
  input  logic             wr_init,
  input  logic [IDX_W-1:0] wr_idx,
  input  logic             wr_taken
);

  logic [1:0] mem [2**IDX_W];

  // Read data is consumed at the same edge that commits a write, so a
  // same-index predict always sees the pre-update counter.
  assign rd_cnt = mem[rd_idx];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_idx] <= wr_init ? WNT : sat_update(mem[wr_idx], wr_taken);
    end
  end

endmodule

// File: rtl/gshare_bp.sv
// gshare predictor top: init sweep controller, speculative global history with
// misprediction recovery, PC^GHR index hashing and saturating statistics.
module gshare_bp
  import gshare_pkg::*;
#(
  parameter int unsigned ADDR_W = 11,
  parameter int unsigned IDX_W  = 10,
  parameter int unsigned GHR_W  = 8,
  parameter int unsigned CNT_W  = 16
) (
  input  logic      clk,
  input  logic      reset,
  gshare_bp_if.slave bp
);

  state_e             state_q, state_d;
  logic [IDX_W-1:0]   init_ptr_q, init_ptr_d;
  logic [GHR_W-1:0]   ghr_q, ghr_d;
  logic               rsp_valid_q;
  logic               pred_taken_q;
  logic [GHR_W-1:0]   pred_ghr_q;
  logic [CNT_W-1:0]   stat_upd_q, stat_upd_d;
  logic [CNT_W-1:0]   stat_mis_q, stat_mis_d;

  logic               run;
  logic               pred_acc;
  logic               upd_acc;
  logic [IDX_W-1:0]   pred_idx;
  logic [IDX_W-1:0]   upd_idx;
  logic [1:0]         rd_cnt;

  assign run      = (state_q == StRun);
  assign pred_acc = run & bp.pred_valid;
  assign upd_acc  = run & bp.upd_valid;
  assign pred_idx = bp.pred_addr[IDX_W-1:0] ^ IDX_W'(ghr_q);
  assign upd_idx  = bp.upd_addr[IDX_W-1:0] ^ IDX_W'(bp.upd_ghr);

  gshare_pht #(
    .IDX_W (IDX_W)
  ) u_pht (
    .clk      (clk),
    .rd_idx   (pred_idx),
    .rd_cnt   (rd_cnt),
    .wr_en    (~run | upd_acc),
    .wr_init  (~run),
    .wr_idx   (run ? upd_idx : init_ptr_q),
    .wr_taken (bp.upd_taken)
  );

  always_comb begin
    state_d    = state_q;
    init_ptr_d = init_ptr_q;
    unique case (state_q)
      StInit: begin
        init_ptr_d = init_ptr_q + IDX_W'(1);
        if (init_ptr_q == '1) begin
          state_d = StRun;
        end
      end
      StRun: begin
      end
    endcase
  end

  // Recovery wins over the speculative shift of a same-cycle prediction.
  always_comb begin
    ghr_d = ghr_q;
    if (upd_acc && bp.upd_mispredict) begin
      ghr_d = {bp.upd_ghr[GHR_W-2:0], bp.upd_taken};
    end else if (pred_acc) begin
      ghr_d = {ghr_q[GHR_W-2:0], rd_cnt[1]};
    end
  end

  always_comb begin
    stat_upd_d = stat_upd_q;
    stat_mis_d = stat_mis_q;
    if (upd_acc && (stat_upd_q != '1)) begin
      stat_upd_d = stat_upd_q + CNT_W'(1);
    end
    if (upd_acc && bp.upd_mispredict && (stat_mis_q != '1)) begin
      stat_mis_d = stat_mis_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= StInit;
      init_ptr_q   <= '0;
      ghr_q        <= '0;
      rsp_valid_q  <= 1'b0;
      pred_taken_q <= 1'b0;
      pred_ghr_q   <= '0;
      stat_upd_q   <= '0;
      stat_mis_q   <= '0;
    end else begin
      state_q     <= state_d;
      init_ptr_q  <= init_ptr_d;
      ghr_q       <= ghr_d;
      rsp_valid_q <= pred_acc;
      if (pred_acc) begin
        pred_taken_q <= rd_cnt[1];
        pred_ghr_q   <= ghr_q;
      end
      stat_upd_q <= stat_upd_d;
      stat_mis_q <= stat_mis_d;
    end
  end

  assign bp.ready          = run;
  assign bp.pred_rsp_valid = rsp_valid_q;
  assign bp.pred_taken     = pred_taken_q;
  assign bp.pred_ghr       = pred_ghr_q;
  assign bp.stat_updates   = stat_upd_q;
  assign bp.stat_mispreds  = stat_mis_q;

endmodule

// File: tb/tb_gshare_bp.sv
// Directed bench for gshare_bp: stimulus pushes expected {taken, ghr} responses,
// a negedge monitor pops and compares whenever the predictor answers.
module tb_gshare_bp;

  logic clk   = 1'b0;
  logic reset = 1'b0;
  int   n_checks = 0;
  int   n_fail   = 0;
  logic [8:0] exp_q [$];
  logic [8:0] mon_e;

  gshare_bp_if #(.ADDR_W(11), .GHR_W(8), .CNT_W(4)) bp_if ();

  gshare_bp #(
    .ADDR_W (11),
    .IDX_W  (10),
    .GHR_W  (8),
    .CNT_W  (4)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bp    (bp_if)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (reset && bp_if.pred_rsp_valid) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_rsp", 32'(bp_if.pred_rsp_valid), 32'd0);
      end else begin
        mon_e = exp_q.pop_front();
        chk("pred_rsp", 32'({bp_if.pred_taken, bp_if.pred_ghr}), 32'(mon_e));
      end
    end
  end

  task automatic idle();
    bp_if.pred_valid     = 1'b0;
    bp_if.pred_addr      = '0;
    bp_if.upd_valid      = 1'b0;
    bp_if.upd_addr       = '0;
    bp_if.upd_ghr        = '0;
    bp_if.upd_taken      = 1'b0;
    bp_if.upd_mispredict = 1'b0;
  endtask

  // Drive one cycle of traffic starting at a negedge; returns at the next negedge.
  task automatic issue(input logic pv, input logic [10:0] pa, input logic et,
                       input logic [7:0] eg, input logic uv, input logic [10:0] ua,
                       input logic [7:0] ug, input logic ut, input logic um);
    bp_if.pred_valid     = pv;
    bp_if.pred_addr      = pa;
    bp_if.upd_valid      = uv;
    bp_if.upd_addr       = ua;
    bp_if.upd_ghr        = ug;
    bp_if.upd_taken      = ut;
    bp_if.upd_mispredict = um;
    if (pv) exp_q.push_back({et, eg});
    @(negedge clk);
    idle();
  endtask

  task automatic predict(input logic [10:0] pa, input logic et, input logic [7:0] eg);
    issue(1'b1, pa, et, eg, 1'b0, 11'h0, 8'h0, 1'b0, 1'b0);
  endtask

  task automatic update(input logic [10:0] ua, input logic [7:0] ug, input logic ut,
                        input logic um);
    issue(1'b0, 11'h0, 1'b0, 8'h0, 1'b1, ua, ug, ut, um);
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_ready"}, 32'(bp_if.ready), 32'd0);
    chk({tag, "_rsp_valid"}, 32'(bp_if.pred_rsp_valid), 32'd0);
    chk({tag, "_pred_taken"}, 32'(bp_if.pred_taken), 32'd0);
    chk({tag, "_pred_ghr"}, 32'(bp_if.pred_ghr), 32'd0);
    chk({tag, "_stat_updates"}, 32'(bp_if.stat_updates), 32'd0);
    chk({tag, "_stat_mispreds"}, 32'(bp_if.stat_mispreds), 32'd0);
  endtask

  // Called at the negedge where reset is released; junk traffic must be ignored.
  task automatic wait_init(input string tag);
    int n = 0;
    while (!bp_if.ready && n < 2000) begin
      bp_if.pred_valid     = (n < 10);
      bp_if.pred_addr      = 11'(n);
      bp_if.upd_valid      = (n < 10);
      bp_if.upd_addr       = 11'(n);
      bp_if.upd_taken      = 1'b1;
      bp_if.upd_mispredict = 1'b1;
      @(negedge clk);
      n++;
    end
    idle();
    chk({tag, "_cycles"}, 32'(n), 32'd1024);
    chk({tag, "_stat_updates"}, 32'(bp_if.stat_updates), 32'd0);
    chk({tag, "_stat_mispreds"}, 32'(bp_if.stat_mispreds), 32'd0);
  endtask

  initial begin
    idle();
    reset = 1'b0;
    repeat (3) @(negedge clk);
    check_zero("reset");
    reset = 1'b1;
    wait_init("init");

    // Every entry starts WNT; all not-taken keeps ghr at 0 so index == addr.
    for (int i = 0; i < 1024; i++) predict(11'(i), 1'b0, 8'h00);

    // Two taken updates move 01 -> 11.
    predict(11'h005, 1'b0, 8'h00);
    update(11'h005, 8'h00, 1'b1, 1'b0);
    update(11'h005, 8'h00, 1'b1, 1'b0);
    predict(11'h005, 1'b1, 8'h00);                 // ghr -> 01

    // Saturate at 11, then one not-taken leaves 10.
    repeat (4) update(11'h00A, 8'h00, 1'b1, 1'b0);
    update(11'h00A, 8'h00, 1'b0, 1'b0);
    predict(11'h00B, 1'b1, 8'h01);                 // idx 0x00A, ghr -> 03

    // Recovery beats same-cycle speculative shift; prediction uses old ghr.
    issue(1'b1, 11'h100, 1'b0, 8'h03, 1'b1, 11'h200, 8'h01, 1'b0, 1'b1);
    predict(11'h300, 1'b0, 8'h02);                 // ghr -> 04

    // Read-before-write on a shared index holding 01.
    issue(1'b1, 11'h010, 1'b0, 8'h04, 1'b1, 11'h014, 8'h00, 1'b1, 1'b0);
    predict(11'h01C, 1'b1, 8'h08);                 // idx 0x014 now 10

    chk("stat_updates_9", 32'(bp_if.stat_updates), 32'd9);
    chk("stat_mispreds_1", 32'(bp_if.stat_mispreds), 32'd1);

    repeat (10) update(11'h050, 8'h00, 1'b1, 1'b1);
    chk("stat_updates_sat", 32'(bp_if.stat_updates), 32'd15);
    chk("stat_mispreds_11", 32'(bp_if.stat_mispreds), 32'd11);
    repeat (10) update(11'h050, 8'h00, 1'b1, 1'b1);
    chk("stat_updates_hold", 32'(bp_if.stat_updates), 32'd15);
    chk("stat_mispreds_sat", 32'(bp_if.stat_mispreds), 32'd15);

    // Last response is held until the next one.
    chk("held_pred_taken", 32'(bp_if.pred_taken), 32'd1);
    chk("held_pred_ghr", 32'(bp_if.pred_ghr), 32'h08);

    #1 reset = 1'b0;
    #1 check_zero("midreset");
    @(negedge clk);
    reset = 1'b1;
    wait_init("reinit");
    predict(11'h014, 1'b0, 8'h00);

    repeat (3) @(negedge clk);
    chk("queue_empty", 32'(exp_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
